mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: A_WIDTH, default 32, width of all address buses.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports pN_req  input  1  access request, N in {0 = instruction fetch, 1 = data}.
REQ-005 SHALL have ports pN_addr  input  A_WIDTH  byte address.
REQ-006 SHALL have ports pN_bytes  input  3  size code: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-007 SHALL have ports pN_we  input  1  write enable, and pN_wd  input  32  write data.
REQ-008 SHALL have ports pN_gnt  output  1  one-cycle accept pulse.
REQ-009 SHALL have ports pN_rvalid  output  1  one-cycle completion pulse, with pN_rdata  output  32 and pN_err  output  1.
REQ-010 SHALL have RAM-side ports: ram_address  output  A_WIDTH; ram_bytes  output  3; ram_we  output  1; ram_wd  output  32; ram_dout  input  32 (combinational read, write on clk edge).
REQ-011 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-013 In IDLE with any pN_req high, SHALL select one requester, pulse its pN_gnt, and latch its addr, bytes, we, wd and port id.
REQ-014 pN_gnt SHALL be asserted only in IDLE and only for the selected port; requesters hold req and operands stable until gnt.
REQ-015 Valid accepted request: IDLE -> ACCESS -> RESP -> IDLE; pN_rvalid pulses in RESP, two cycles after the gnt cycle.
REQ-016 In ACCESS, SHALL drive ram_address/ram_bytes/ram_wd from the latched values; ram_we = latched we; ram_dout captured into the rdata register at the end of ACCESS.
REQ-017 ram_we SHALL be 0 in every state other than ACCESS.
REQ-018 Outside ACCESS, ram_address/ram_bytes/ram_wd SHALL hold the last latched values.
REQ-019 Error request (half at addr[0]=1; word at addr[1:0]!=0; bytes code 011/110/111; write with 100/101) SHALL go IDLE -> RESP, skipping ACCESS: no RAM write, pN_err=1, pN_rdata=0.
REQ-020 For writes, pN_rdata in RESP SHALL be 0 with pN_err=0.
REQ-021 pN_rvalid, pN_err and pN_rdata SHALL be qualified by, and driven to the originating port only during, RESP; otherwise pN_rvalid=0, pN_err=0, pN_rdata=0.
REQ-022 No request SHALL be accepted in ACCESS or RESP; peak throughput one access per 3 cycles (error: per 2).
REQ-023 A single requesting port SHALL be granted regardless of arbitration history.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE and all outputs to 0 (ram_bytes 000, ram_we 0, busy 0), independent of clk.
REQ-025 Reset during ACCESS SHALL abort the access: ram_we drops at once, no pN_rvalid is ever produced for it.
REQ-026 Arbitration history (last-granted port) SHALL reset to port 1, so port 0 wins the first tie under round-robin.

Configuration
REQ-027 Macro MEM_ARB_RR_EN defined: simultaneous requests SHALL be granted round-robin, to the port not granted last.
REQ-028 MEM_ARB_RR_EN undefined: simultaneous requests SHALL always grant port 1 (data) over port 0; no history register.

Verification
REQ-029 Port 1 word write addr 0x10 wd 0xDEADBEEF, then port 0 lw 0x10 -> p0_rvalid on 2nd cycle after p0_gnt, p0_rdata 0xDEADBEEF, ram_we high exactly one cycle.
REQ-030 RAM byte 0x20 = 0x80; port 1 bytes 000 at 0x20 -> rdata 0xFFFFFF80; bytes 100 -> 0x00000080.
REQ-031 Port 1 word write addr 0x12 -> p1_rvalid and p1_err one cycle after p1_gnt, p1_rdata 0, ram_we never high, RAM unchanged.
REQ-032 Both ports requesting continuously, 4 accesses -> with MEM_ARB_RR_EN grants 0,1,0,1; without, 1,1,1,1 and p0 starved.
REQ-033 rst_n pulsed low during ACCESS of a word write -> ram_we falls asynchronously, busy 0, no rvalid; next request completes normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : One requester-side port of the memory arbiter: request and
//               operands from the requester, accept / completion back to it.
// Revision    : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
   parameter int A_WIDTH = 32
);
   logic               req;
   logic [A_WIDTH-1:0] addr;
   logic [2:0]         bytes;
   logic               we;
   logic [31:0]        wd;
   logic               gnt;
   logic               rvalid;
   logic [31:0]        rdata;
   logic               err;

   // Requester side
   modport master (
      output req, addr, bytes, we, wd,
      input  gnt, rvalid, rdata, err
   );

   // Arbiter side
   modport slave (
      input  req, addr, bytes, we, wd,
      output gnt, rvalid, rdata, err
   );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port (instruction fetch / data) arbiter in front of a
//               single-port RAM. IDLE accepts one request, ACCESS drives the
//               RAM for one cycle, RESP returns the completion to the owner.
//               Misaligned or illegal requests skip ACCESS and complete with
//               err set.
//               Build option MEM_ARB_RR_EN: round-robin on simultaneous
//               requests; otherwise the data port (p1) always wins.
// Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
   parameter int A_WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   mem_arbiter_if.slave       p0,
   mem_arbiter_if.slave       p1,
   output logic [A_WIDTH-1:0] ram_address,
   output logic [2:0]         ram_bytes,
   output logic               ram_we,
   output logic [31:0]        ram_wd,
   input  logic [31:0]        ram_dout,
   output logic               busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [A_WIDTH-1:0] r_addr;
   logic [2:0]         r_bytes;
   logic               r_we;
   logic [31:0]        r_wd;
   logic               r_port;
   logic               r_err;
   logic [31:0]        r_rdata;

   logic               w_any;
   logic               w_sel;
   logic               w_accept;
   logic [A_WIDTH-1:0] w_addr;
   logic [2:0]         w_bytes;
   logic               w_we;
   logic [31:0]        w_wd;
   logic               w_sel_err;
   logic               w_resp;

`ifdef MEM_ARB_RR_EN
   logic               r_last;
`endif

   // Illegal size codes, misalignment, and unsigned-size writes are errors
   function automatic logic f_is_err(input logic [2:0] bytes,
                                     input logic [1:0] a,
                                     input logic       we);
      logic e;
      case (bytes)
         3'b000:  e = 1'b0;
         3'b001:  e = a[0];
         3'b010:  e = |a;
         3'b100:  e = we;
         3'b101:  e = a[0] | we;
         default: e = 1'b1;
      endcase
      return e;
   endfunction

   // Port selection and selected-operand mux
   always_comb begin
      w_any = p0.req | p1.req;
`ifdef MEM_ARB_RR_EN
      // On a tie the port not granted last time wins
      if (p0.req && p1.req) w_sel = ~r_last;
      else                  w_sel = p1.req;
`else
      // Data port always wins a tie
      w_sel = p1.req;
`endif
      w_addr    = w_sel ? p1.addr  : p0.addr;
      w_bytes   = w_sel ? p1.bytes : p0.bytes;
      w_we      = w_sel ? p1.we    : p0.we;
      w_wd      = w_sel ? p1.wd    : p0.wd;
      w_sel_err = f_is_err(w_bytes, w_addr[1:0], w_we);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state and accept decode
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_accept    = 1'b1;
               w_state_nxt = w_sel_err ? RESP : ACCESS;
            end
         end
         ACCESS:  w_state_nxt = RESP;
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Request latch and read-data capture at the end of ACCESS
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr  <= '0;
         r_bytes <= 3'b000;
         r_we    <= 1'b0;
         r_wd    <= 32'h0;
         r_port  <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= 32'h0;
      end else if (w_accept) begin
         r_addr  <= w_addr;
         r_bytes <= w_bytes;
         r_we    <= w_we;
         r_wd    <= w_wd;
         r_port  <= w_sel;
         r_err   <= w_sel_err;
         r_rdata <= 32'h0;
      end else if (r_state == ACCESS) begin
         // Writes return zero data
         r_rdata <= r_we ? 32'h0 : ram_dout;
      end
   end

`ifdef MEM_ARB_RR_EN
   // Arbitration history; starts at port 1 so port 0 wins the first tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_last <= 1'b1;
      else if (w_accept) r_last <= w_sel;
   end
`endif

   // RAM side holds the last latched request; write strobe only in ACCESS
   assign ram_address = r_addr;
   assign ram_bytes   = r_bytes;
   assign ram_wd      = r_wd;
   assign ram_we      = (r_state == ACCESS) & r_we;
   assign busy        = (r_state != IDLE);

   // Grants are combinational in IDLE; gated by rst_n so reset silences them
   assign p0.gnt = w_accept & ~w_sel & rst_n;
   assign p1.gnt = w_accept &  w_sel & rst_n;

   // Completion is routed only to the owning port and only in RESP
   assign w_resp    = (r_state == RESP);
   assign p0.rvalid = w_resp & ~r_port;
   assign p1.rvalid = w_resp &  r_port;
   assign p0.err    = w_resp & ~r_port & r_err;
   assign p1.err    = w_resp &  r_port & r_err;
   assign p0.rdata  = (w_resp & ~r_port) ? r_rdata : 32'h0;
   assign p1.rdata  = (w_resp &  r_port) ? r_rdata : 32'h0;

endmodule
`default_nettype wire
